// File: rtl/fifo_control.sv
// Pointer, occupancy, flag and error control for a power-of-two deep FIFO memory.
// Define FIFO_ERR_STICKY_EN to make error hold until reset instead of pulsing.
module fifo_control #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int unsigned CntW  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DepthCnt = CntW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfLevel  = CntW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AeLevel  = CntW'(AE_THRESH);

    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("fifo_control: ADDR_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StEmpty  = 2'd1,
        StActive = 2'd2,
        StFull   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  error_q, error_d;
    logic                  overflow, underflow;

    assign fifo_full    = (count_q == DepthCnt);
    assign fifo_empty   = (count_q == '0);
    assign almost_full  = (count_q >= AfLevel);
    assign almost_empty = (count_q <= AeLevel);

    // INIT blocks both strobes so the first cycle out of reset is always idle.
    assign write_enable = push && !fifo_full  && (state_q != StInit);
    assign read_enable  = pop  && !fifo_empty && (state_q != StInit);

    assign overflow  = push && fifo_full  && (state_q != StInit);
    assign underflow = pop  && fifo_empty && (state_q != StInit);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (write_enable) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (read_enable) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        unique case ({write_enable, read_enable})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
`ifdef FIFO_ERR_STICKY_EN
        error_d = error_q || overflow || underflow;
`else
        error_d = overflow || underflow;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: begin
                state_d = StEmpty;
            end
            StEmpty: begin
                if (write_enable) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (count_d == '0) begin
                    state_d = StEmpty;
                end else if (count_d == DepthCnt) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (read_enable) begin
                    state_d = StActive;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= StInit;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    assign wr_ptr     = wr_ptr_q;
    assign rd_ptr     = rd_ptr_q;
    assign fifo_count = count_q;
    assign error      = error_q;

endmodule

// File: tb/tb_fifo_control.sv
// Directed bench for fifo_control at ADDR_WIDTH=3 (DEPTH=8, AF_THRESH=6, AE_THRESH=2).
module tb_fifo_control;

    localparam int unsigned AW = 3;

`ifdef FIFO_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic          clk;
    logic          reset_L;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          write_enable;
    logic          read_enable;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    int total = 0;
    int bad   = 0;

    fifo_control #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .pop          (pop),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic p, input logic q);
        @(negedge clk);
        push = p;
        pop  = q;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".wr_ptr"}, int'(wr_ptr), 0);
        check({tag, ".rd_ptr"}, int'(rd_ptr), 0);
        check({tag, ".count"}, int'(fifo_count), 0);
        check({tag, ".error"}, int'(error), 0);
        check({tag, ".empty"}, int'(fifo_empty), 1);
        check({tag, ".aempty"}, int'(almost_empty), 1);
        check({tag, ".full"}, int'(fifo_full), 0);
        check({tag, ".afull"}, int'(almost_full), 0);
        check({tag, ".we"}, int'(write_enable), 0);
        check({tag, ".re"}, int'(read_enable), 0);
    endtask

    initial begin
        reset_L = 1'b0;
        push    = 1'b1;
        pop     = 1'b0;
        #2;
        check_reset_outputs("rst");
        tick();
        tick();

        // Release between edges; INIT must gate the pending push.
        set_in(1'b1, 1'b0);
        reset_L = 1'b1;
        #1;
        check("init.we", int'(write_enable), 0);
        tick();
        check("init.count", int'(fifo_count), 0);
        check("init.wr_ptr", int'(wr_ptr), 0);

        // Fill: 8 pushes.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0);
            check("fill.wr_ptr", int'(wr_ptr), i);
            check("fill.we", int'(write_enable), 1);
            tick();
            check("fill.count", int'(fifo_count), i + 1);
            check("fill.afull", int'(almost_full), (i + 1 >= 6) ? 1 : 0);
            check("fill.full", int'(fifo_full), (i + 1 == 8) ? 1 : 0);
            check("fill.aempty", int'(almost_empty), (i + 1 <= 2) ? 1 : 0);
            check("fill.empty", int'(fifo_empty), 0);
        end
        check("fill.wr_wrap", int'(wr_ptr), 0);
        check("fill.error", int'(error), 0);

        // Overflow.
        set_in(1'b1, 1'b0);
        check("ovf.we", int'(write_enable), 0);
        tick();
        check("ovf.wr_ptr", int'(wr_ptr), 0);
        check("ovf.count", int'(fifo_count), 8);
        check("ovf.error", int'(error), 1);
        set_in(1'b0, 1'b0);
        tick();
        check("ovf.error_after", int'(error), int'(STICKY));

        // Drain: 8 pops, the first with a rejected push alongside.
        for (int i = 0; i < 8; i++) begin
            set_in((i == 0) ? 1'b1 : 1'b0, 1'b1);
            check("drain.rd_ptr", int'(rd_ptr), i);
            check("drain.re", int'(read_enable), 1);
            check("drain.we", int'(write_enable), 0);
            tick();
            check("drain.count", int'(fifo_count), 7 - i);
            check("drain.empty", int'(fifo_empty), (7 - i == 0) ? 1 : 0);
            check("drain.aempty", int'(almost_empty), (7 - i <= 2) ? 1 : 0);
            check("drain.afull", int'(almost_full), (7 - i >= 6) ? 1 : 0);
            check("drain.error", int'(error), (i == 0) ? 1 : int'(STICKY));
        end
        check("drain.rd_wrap", int'(rd_ptr), 0);
        check("drain.wr_ptr", int'(wr_ptr), 0);

        // Underflow with simultaneous push on empty.
        set_in(1'b1, 1'b1);
        check("unf.re", int'(read_enable), 0);
        check("unf.we", int'(write_enable), 1);
        tick();
        check("unf.count", int'(fifo_count), 1);
        check("unf.error", int'(error), 1);
        check("unf.wr_ptr", int'(wr_ptr), 1);
        check("unf.rd_ptr", int'(rd_ptr), 0);
        set_in(1'b0, 1'b0);
        tick();
        check("unf.error_after", int'(error), int'(STICKY));

        // Bring count to 4, then 10 simultaneous push/pop cycles.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0);
            tick();
        end
        check("mid.count", int'(fifo_count), 4);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b1);
            tick();
            check("both.count", int'(fifo_count), 4);
        end
        check("both.wr_ptr", int'(wr_ptr), 6);
        check("both.rd_ptr", int'(rd_ptr), 2);

        // count=5, then asynchronous reset between edges.
        set_in(1'b1, 1'b0);
        tick();
        check("pre_rst.count", int'(fifo_count), 5);
        set_in(1'b1, 1'b1);
        reset_L = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        #1;
        reset_L = 1'b1;
        #1;
        check("rel.we", int'(write_enable), 0);
        check("rel.re", int'(read_enable), 0);
        tick();
        check("rel.count", int'(fifo_count), 0);
        check("rel.wr_ptr", int'(wr_ptr), 0);
        set_in(1'b1, 1'b0);
        check("rel.we_empty", int'(write_enable), 1);
        tick();
        check("rel.count1", int'(fifo_count), 1);
        check("rel.wr_ptr1", int'(wr_ptr), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_control.md
FIFO_CONTROL -- requirements
Module: fifo_control

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set pointer width; depth DEPTH = 2^ADDR_WIDTH entries.
REQ-002 Parameter AF_THRESH, default DEPTH-2, SHALL set the almost_full occupancy level.
REQ-003 Parameter AE_THRESH, default 2, SHALL set the almost_empty occupancy level.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_L  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 push  input  1  SHALL request a write of the current FIFO_data_in word into memory.
REQ-007 pop  input  1  SHALL request a read of the oldest word from memory.
REQ-008 wr_ptr  output  ADDR_WIDTH  SHALL be the memory write address.
REQ-009 rd_ptr  output  ADDR_WIDTH  SHALL be the memory read address.
REQ-010 write_enable  output  1  SHALL be the memory write strobe.
REQ-011 read_enable  output  1  SHALL be the memory read strobe.
REQ-012 fifo_count  output  ADDR_WIDTH+1  SHALL be current occupancy, 0..DEPTH.
REQ-013 fifo_full, fifo_empty, almost_full, almost_empty  output  1 each  SHALL be the occupancy flags.
REQ-014 error  output  1  SHALL flag overflow or underflow.

Function
REQ-015 write_enable SHALL be combinational: push AND NOT fifo_full.
REQ-016 read_enable SHALL be combinational: pop AND NOT fifo_empty.
REQ-017 On a clk edge with write_enable=1, wr_ptr SHALL increment by 1, modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-018 On a clk edge with read_enable=1, rd_ptr SHALL increment by 1, modulo DEPTH.
REQ-019 fifo_count SHALL update per edge: +1 write only, -1 read only, unchanged for both or neither; never outside 0..DEPTH.
REQ-020 Flags SHALL derive from registered fifo_count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-021 Push while full SHALL be rejected (no write, no pointer move) even if pop is asserted in the same cycle; the pop proceeds.
REQ-022 Pop while empty SHALL be rejected (no read, no pointer move) even if push is asserted in the same cycle; the push proceeds.
REQ-023 Rejected push (overflow) or rejected pop (underflow) SHALL assert error from the following edge.
REQ-024 FSM state SHALL be one of INIT, EMPTY, ACTIVE, FULL, registered.
REQ-025 INIT SHALL be entered on reset; the first edge after reset_L rises SHALL move to EMPTY; write_enable and read_enable SHALL be 0 in INIT regardless of push/pop.
REQ-026 EMPTY->ACTIVE on an accepted write; ACTIVE->EMPTY when count goes 1->0; ACTIVE->FULL when count goes DEPTH-1->DEPTH; FULL->ACTIVE on an accepted read; otherwise hold.
REQ-027 Single-entry FIFO behaviour (DEPTH=1 via ADDR_WIDTH=0) SHALL NOT be supported; ADDR_WIDTH SHALL be >= 1.

Reset
REQ-028 reset_L=0 SHALL immediately force wr_ptr=0, rd_ptr=0, fifo_count=0, error=0, state INIT, write_enable=0, read_enable=0.
REQ-029 Under reset fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
REQ-030 Reset asserted mid-operation SHALL discard all occupancy; memory contents are not cleared and SHALL be treated as invalid.

Configuration
REQ-031 Macro FIFO_ERR_STICKY_EN defined: error SHALL stay 1 after the first overflow/underflow until reset_L=0.
REQ-032 Macro FIFO_ERR_STICKY_EN undefined: error SHALL be 1 for exactly the one cycle after each overflow/underflow edge, else 0.

Verification (ADDR_WIDTH=3, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-033 Reset, then 8 consecutive pushes -> wr_ptr 0..7 then 0, count=8, fifo_full=1, almost_full=1 from 6th push, state FULL.
REQ-034 From full, 9th push without pop -> write_enable=0, wr_ptr stays 0, count=8, error=1 next cycle.
REQ-035 From full, 8 pops -> rd_ptr wraps 7->0, count=0, fifo_empty=1, almost_empty=1 at count<=2, state EMPTY.
REQ-036 count=4, push and pop together for 10 cycles -> count stays 4, both pointers advance 10 (mod 8).
REQ-037 Empty, pop with push same cycle -> read_enable=0, write_enable=1, count=1, error=1; check pulse vs sticky per FIFO_ERR_STICKY_EN.
REQ-038 count=5, reset_L pulsed low between edges -> outputs reset immediately; first edge after release -> state EMPTY, enables 0 during INIT.
